// File: rtl/hs_protocol_monitor.sv
// hs_protocol_monitor: passive valid/ready checker for NUM_CH independent links.
// Each channel runs a small IDLE/WAIT/HS FSM on the sampled (valid, ready) pair,
// counts handshakes, and raises sticky, set-dominant error flags.
module hs_protocol_monitor #(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT     = 16,
  parameter int SINGLE_BEAT = 1,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        valid,
  input  logic [NUM_CH-1:0]        ready,
  input  logic [NUM_CH*DATA_W-1:0] data,
  input  logic                     clr_err,
  output logic [NUM_CH-1:0]        hs_pulse,
  output logic [NUM_CH*CNT_W-1:0]  hs_count,
  output logic [NUM_CH-1:0]        err_drop,
  output logic [NUM_CH-1:0]        err_stable,
  output logic [NUM_CH-1:0]        err_timeout,
  output logic [NUM_CH-1:0]        err_linger,
  output logic                     err_any
);

  // Stall counter only needs to reach TIMEOUT, where it saturates.
  localparam int STALL_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HS   = 2'd2;

  // Next-state error summary per channel, so err_any lines up with the flags.
  logic [NUM_CH-1:0] ch_err_d;
  logic              err_any_q;
  logic              err_any_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [1:0]         state_q, state_d;
      logic [DATA_W-1:0]  cap_q, cap_d;
      logic [STALL_W-1:0] stall_q, stall_d;
      logic [STALL_W-1:0] stall_inc;
      logic               pulse_q, pulse_d;
      logic [CNT_W-1:0]   cnt_q, cnt_d;
      logic               drop_q, drop_d;
      logic               stable_q, stable_d;
      logic               timeout_q, timeout_d;
      logic               linger_q, linger_d;
      logic               set_drop, set_stable, set_timeout, set_linger;
      logic               as_idle;
      logic               v, r;
      logic [DATA_W-1:0]  d;

      assign v = valid[gi];
      assign r = ready[gi];
      assign d = data[gi*DATA_W +: DATA_W];
      assign stall_inc = stall_q + 1'b1;

      // Channel FSM, handshake counter and error event detection.
      always_comb begin
        state_d     = state_q;
        cap_d       = cap_q;
        stall_d     = '0;
        pulse_d     = 1'b0;
        cnt_d       = cnt_q;
        set_drop    = 1'b0;
        set_stable  = 1'b0;
        set_timeout = 1'b0;
        set_linger  = 1'b0;
        as_idle     = 1'b0;

        case (state_q)
          ST_WAIT: begin
            if (!v) begin
              state_d  = ST_IDLE;
              set_drop = 1'b1;
            end else if (r) begin
              state_d = ST_HS;
              pulse_d = 1'b1;
              if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            end else begin
              // Still stalled: one stable flag per payload change, then recapture.
              if (d != cap_q) begin
                set_stable = 1'b1;
                cap_d      = d;
              end
              stall_d = stall_q;
              if (stall_q < STALL_W'(TIMEOUT)) begin
                stall_d = stall_inc;
                if (stall_inc == STALL_W'(TIMEOUT)) set_timeout = 1'b1;
              end
            end
          end
          ST_HS: begin
            if (SINGLE_BEAT != 0) begin
              if (!v) begin
                state_d = ST_IDLE;
              end else begin
                // Lingering valid is flagged but also treated as a fresh transfer.
                set_linger = 1'b1;
                as_idle    = 1'b1;
              end
            end else begin
              as_idle = 1'b1;
            end
          end
          default: as_idle = 1'b1;
        endcase

        if (as_idle) begin
          if (v && r) begin
            state_d = ST_HS;
            pulse_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          end else if (v) begin
            state_d = ST_WAIT;
            cap_d   = d;
            stall_d = STALL_W'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end

        // Set-dominant sticky flags.
        drop_d    = set_drop    | (drop_q    & ~clr_err);
        stable_d  = set_stable  | (stable_q  & ~clr_err);
        timeout_d = set_timeout | (timeout_q & ~clr_err);
        linger_d  = set_linger  | (linger_q  & ~clr_err);
      end

      assign ch_err_d[gi] = drop_d | stable_d | timeout_d | linger_d;

      // Channel state registers with synchronous active-low reset.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_q   <= ST_IDLE;
          cap_q     <= '0;
          stall_q   <= '0;
          pulse_q   <= 1'b0;
          cnt_q     <= '0;
          drop_q    <= 1'b0;
          stable_q  <= 1'b0;
          timeout_q <= 1'b0;
          linger_q  <= 1'b0;
        end else begin
          state_q   <= state_d;
          cap_q     <= cap_d;
          stall_q   <= stall_d;
          pulse_q   <= pulse_d;
          cnt_q     <= cnt_d;
          drop_q    <= drop_d;
          stable_q  <= stable_d;
          timeout_q <= timeout_d;
          linger_q  <= linger_d;
        end
      end

      assign hs_pulse[gi]                 = pulse_q;
      assign hs_count[gi*CNT_W +: CNT_W]  = cnt_q;
      assign err_drop[gi]                 = drop_q;
      assign err_stable[gi]               = stable_q;
      assign err_timeout[gi]              = timeout_q;
      assign err_linger[gi]               = linger_q;
    end
  endgenerate

  // Summary error bit computed from next-state flags of every channel.
  always_comb begin
    err_any_d = |ch_err_d;
  end

  // Registered summary error output.
  always_ff @(posedge clk) begin
    if (!rst_n) err_any_q <= 1'b0;
    else        err_any_q <= err_any_d;
  end

  assign err_any = err_any_q;

endmodule

// File: tb/tb_hs_protocol_monitor.sv
// Directed testbench for hs_protocol_monitor: a SINGLE_BEAT=1 and a
// SINGLE_BEAT=0 instance share the same stimulus (2 channels, CNT_W=4).
module tb_hs_protocol_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  valid;
  logic [1:0]  ready;
  logic [15:0] data;
  logic        clr_err;

  logic [1:0] a_pulse, a_drop, a_stable, a_timeout, a_linger;
  logic [7:0] a_count;
  logic       a_any;
  logic [1:0] b_pulse, b_drop, b_stable, b_timeout, b_linger;
  logic [7:0] b_count;
  logic       b_any;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hs_protocol_monitor #(.NUM_CH(2), .DATA_W(8), .TIMEOUT(4), .SINGLE_BEAT(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .valid(valid), .ready(ready), .data(data), .clr_err(clr_err),
    .hs_pulse(a_pulse), .hs_count(a_count), .err_drop(a_drop), .err_stable(a_stable),
    .err_timeout(a_timeout), .err_linger(a_linger), .err_any(a_any)
  );

  hs_protocol_monitor #(.NUM_CH(2), .DATA_W(8), .TIMEOUT(4), .SINGLE_BEAT(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .valid(valid), .ready(ready), .data(data), .clr_err(clr_err),
    .hs_pulse(b_pulse), .hs_count(b_count), .err_drop(b_drop), .err_stable(b_stable),
    .err_timeout(b_timeout), .err_linger(b_linger), .err_any(b_any)
  );

  // Drive one sample, let the edge happen, then settle before checking.
  task automatic cyc(input logic [1:0] v, input logic [1:0] r,
                     input logic [7:0] d0, input logic [7:0] d1);
    valid = v;
    ready = r;
    data  = {d1, d0};
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    clr_err = 1'b0;
    cyc(2'b00, 2'b00, 8'h00, 8'h00);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    clr_err = 1'b0;
    cyc(2'b11, 2'b00, 8'h12, 8'h34);
    checks++;
    if ({a_pulse, a_count, a_drop, a_stable, a_timeout, a_linger, a_any} !== 17'h0) begin
      errors++;
      $display("FAIL reset_a outputs=%h required=0",
               {a_pulse, a_count, a_drop, a_stable, a_timeout, a_linger, a_any});
    end
    checks++;
    if ({b_pulse, b_count, b_drop, b_stable, b_timeout, b_linger, b_any} !== 17'h0) begin
      errors++;
      $display("FAIL reset_b outputs=%h required=0",
               {b_pulse, b_count, b_drop, b_stable, b_timeout, b_linger, b_any});
    end
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_single();
    do_reset();
    cyc(2'b01, 2'b00, 8'h11, 8'h00);
    cyc(2'b01, 2'b00, 8'h11, 8'h00);
    checks++;
    if (a_pulse !== 2'b00) begin
      errors++; $display("FAIL single_prepulse got=%b required=00", a_pulse);
    end
    cyc(2'b01, 2'b01, 8'h11, 8'h00);
    checks++;
    if (a_pulse !== 2'b01 || a_count[3:0] !== 4'd1) begin
      errors++; $display("FAIL single_hs pulse=%b count=%0d required 01/1", a_pulse, a_count[3:0]);
    end
    cyc(2'b00, 2'b00, 8'h00, 8'h00);
    checks++;
    if (a_pulse !== 2'b00 || a_count[3:0] !== 4'd1 || a_any !== 1'b0 || b_any !== 1'b0) begin
      errors++; $display("FAIL single_after pulse=%b count=%0d any=%b/%b required 00/1/0/0",
                         a_pulse, a_count[3:0], a_any, b_any);
    end
    $display("test_single done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      cyc(2'b11, 2'b11, 8'h00, 8'h00);
      checks++;
      if (a_pulse !== 2'b11 || a_count !== {4'(k), 4'(k)}) begin
        errors++; $display("FAIL b2b_hs%0d pulse=%b count=%h required 11/%0d,%0d",
                           k, a_pulse, a_count, k, k);
      end
      cyc(2'b00, 2'b11, 8'h00, 8'h00);
      checks++;
      if (a_pulse !== 2'b00 || a_any !== 1'b0) begin
        errors++; $display("FAIL b2b_gap%0d pulse=%b any=%b required 00/0", k, a_pulse, a_any);
      end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_timeout();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      cyc(2'b01, 2'b00, 8'h33, 8'h00);
      checks++;
      if (a_timeout !== ((k == 4) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL timeout_s%0d got=%b required=%b",
                           k, a_timeout, (k == 4) ? 2'b01 : 2'b00);
      end
    end
    cyc(2'b01, 2'b00, 8'h33, 8'h00);
    cyc(2'b01, 2'b01, 8'h33, 8'h00);
    checks++;
    if (a_count[3:0] !== 4'd1 || a_timeout !== 2'b01 || a_any !== 1'b1) begin
      errors++; $display("FAIL timeout_hs count=%0d timeout=%b any=%b required 1/01/1",
                         a_count[3:0], a_timeout, a_any);
    end
    checks++;
    if ({a_drop[1], a_stable[1], a_timeout[1], a_linger[1]} !== 4'b0000) begin
      errors++; $display("FAIL timeout_ch1 flags=%b required=0000",
                         {a_drop[1], a_stable[1], a_timeout[1], a_linger[1]});
    end
    cyc(2'b00, 2'b00, 8'h00, 8'h00);
    $display("test_timeout done");
  endtask

  task automatic test_linger();
    do_reset();
    cyc(2'b01, 2'b01, 8'h44, 8'h00);
    cyc(2'b01, 2'b00, 8'h44, 8'h00);
    checks++;
    if (a_linger !== 2'b01 || b_linger !== 2'b00) begin
      errors++; $display("FAIL linger_flag a=%b b=%b required 01/00", a_linger, b_linger);
    end
    cyc(2'b01, 2'b01, 8'h44, 8'h00);
    checks++;
    if (a_count[3:0] !== 4'd2 || b_count[3:0] !== 4'd2) begin
      errors++; $display("FAIL linger_count a=%0d b=%0d required 2/2", a_count[3:0], b_count[3:0]);
    end
    checks++;
    if (a_any !== 1'b1 || b_any !== 1'b0 || b_pulse !== 2'b01) begin
      errors++; $display("FAIL linger_any a=%b b=%b bpulse=%b required 1/0/01", a_any, b_any, b_pulse);
    end
    cyc(2'b00, 2'b00, 8'h00, 8'h00);
    $display("test_linger done");
  endtask

  task automatic test_stable_drop();
    do_reset();
    cyc(2'b10, 2'b00, 8'h00, 8'hA5);
    checks++;
    if (a_stable !== 2'b00) begin
      errors++; $display("FAIL stable_pre got=%b required=00", a_stable);
    end
    cyc(2'b10, 2'b00, 8'h00, 8'h5A);
    checks++;
    if (a_stable !== 2'b10) begin
      errors++; $display("FAIL stable_set got=%b required=10", a_stable);
    end
    clr_err = 1'b1;
    cyc(2'b10, 2'b00, 8'h00, 8'h5A);
    checks++;
    if (a_stable !== 2'b00 || a_any !== 1'b0) begin
      errors++; $display("FAIL stable_clr got=%b any=%b required 00/0", a_stable, a_any);
    end
    cyc(2'b00, 2'b00, 8'h00, 8'h00);
    clr_err = 1'b0;
    checks++;
    if (a_drop !== 2'b10 || a_timeout !== 2'b00 || a_any !== 1'b1) begin
      errors++; $display("FAIL drop_clr_same_edge drop=%b timeout=%b any=%b required 10/00/1",
                         a_drop, a_timeout, a_any);
    end
    $display("test_stable_drop done");
  endtask

  task automatic test_reset_mid();
    cyc(2'b01, 2'b00, 8'h10, 8'h00);
    cyc(2'b01, 2'b00, 8'h11, 8'h00);
    checks++;
    if (a_stable !== 2'b01 || a_drop !== 2'b10) begin
      errors++; $display("FAIL mid_setup stable=%b drop=%b required 01/10", a_stable, a_drop);
    end
    rst_n = 1'b0;
    cyc(2'b01, 2'b00, 8'h11, 8'h00);
    rst_n = 1'b1;
    checks++;
    if ({a_pulse, a_count, a_drop, a_stable, a_timeout, a_linger, a_any} !== 17'h0) begin
      errors++; $display("FAIL mid_reset outputs=%h required=0",
                         {a_pulse, a_count, a_drop, a_stable, a_timeout, a_linger, a_any});
    end
    cyc(2'b01, 2'b01, 8'h11, 8'h00);
    checks++;
    if (a_count[3:0] !== 4'd1 || a_pulse !== 2'b01 || a_any !== 1'b0) begin
      errors++; $display("FAIL mid_newtxn count=%0d pulse=%b any=%b required 1/01/0",
                         a_count[3:0], a_pulse, a_any);
    end
    cyc(2'b00, 2'b00, 8'h00, 8'h00);
    $display("test_reset_mid done");
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      cyc(2'b01, 2'b01, 8'h00, 8'h00);
      if (k >= 15) begin
        checks++;
        if (a_count[3:0] !== 4'd15 || b_count[3:0] !== 4'd15 || a_pulse !== 2'b01) begin
          errors++; $display("FAIL saturate_hs%0d a=%0d b=%0d pulse=%b required 15/15/01",
                             k, a_count[3:0], b_count[3:0], a_pulse);
        end
      end
      cyc(2'b00, 2'b00, 8'h00, 8'h00);
    end
    $display("test_saturate done");
  endtask

  initial begin
    rst_n   = 1'b0;
    clr_err = 1'b0;
    valid   = '0;
    ready   = '0;
    data    = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_linger();
    test_stable_drop();
    test_reset_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
